// File: rtl/dma_lb_mc.sv
// dma_lb_mc: NUM_CH independent AXI-Stream loopback channels (H2C -> FIFO -> C2H), one usr_irq per C2H packet.
// Define DMA_LB_STATS_EN to add per-channel pkt_cnt and drop_cnt outputs.
module dma_lb_mc #(
  parameter int TCQ             = 1,
  parameter int DATA_WIDTH      = 128,
  parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
  parameter int NUM_CH          = 2,
  parameter int FIFO_DEPTH      = 16,
  parameter int PEND_W          = 4
) (
  input  logic                              user_clk,
  input  logic                              user_rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      s_axis_h2c_tdata,
  input  logic [NUM_CH*BYTE_BIT_ENABLE-1:0] s_axis_h2c_tkeep,
  input  logic [NUM_CH-1:0]                 s_axis_h2c_tlast,
  input  logic [NUM_CH-1:0]                 s_axis_h2c_tvalid,
  output logic [NUM_CH-1:0]                 s_axis_h2c_tready,
  output logic [NUM_CH*DATA_WIDTH-1:0]      m_axis_c2h_tdata,
  output logic [NUM_CH*BYTE_BIT_ENABLE-1:0] m_axis_c2h_tkeep,
  output logic [NUM_CH-1:0]                 m_axis_c2h_tlast,
  output logic [NUM_CH-1:0]                 m_axis_c2h_tvalid,
  input  logic [NUM_CH-1:0]                 m_axis_c2h_tready,
`ifdef DMA_LB_STATS_EN
  output logic [NUM_CH*32-1:0]              pkt_cnt,
  output logic [NUM_CH*PEND_W-1:0]          drop_cnt,
`endif
  output logic [NUM_CH-1:0]                 irq_req,
  input  logic [NUM_CH-1:0]                 irq_ack
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 1 + BYTE_BIT_ENABLE + DATA_WIDTH;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_GAP} irq_state_e;

  if (NUM_CH < 1 || NUM_CH > 4 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TCQ < 0 || PEND_W < 1) begin : g_param_err
    $error("dma_lb_mc: unsupported parameter set");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_idx;
    logic [CW-1:0] count, count_n, remain;
    logic [EW-1:0] head_q;
    logic          valid_q, ready_q;
    logic          push, pop, pkt_done;
    irq_state_e    state_q, state_n;
    logic          enter_req, irq_q;
    logic [PEND_W-1:0] pend_q;
    logic          pend_sat;

    assign push     = s_axis_h2c_tvalid[c] & ready_q;
    assign pop      = valid_q & m_axis_c2h_tready[c];
    assign pkt_done = pop & head_q[EW-1];
    assign count_n  = count + CW'(push) - CW'(pop);
    // Head for next cycle is taken from words already stored, giving one cycle of latency from empty
    assign remain   = count - CW'(pop);
    assign rd_idx   = rd_ptr + AW'(pop);

    always_ff @(posedge user_clk) begin
      if (push) begin
        mem[wr_ptr] <= {s_axis_h2c_tlast[c],
                        s_axis_h2c_tkeep[c*BYTE_BIT_ENABLE +: BYTE_BIT_ENABLE],
                        s_axis_h2c_tdata[c*DATA_WIDTH +: DATA_WIDTH]};
      end
    end

    // FIFO pointers, occupancy and registered output stage
    always_ff @(posedge user_clk or negedge user_rst) begin
      if (!user_rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        head_q  <= '0;
        valid_q <= 1'b0;
        ready_q <= 1'b0;
      end else begin
        wr_ptr  <= wr_ptr + AW'(push);
        rd_ptr  <= rd_idx;
        count   <= count_n;
        ready_q <= (count_n != CW'(FIFO_DEPTH));
        valid_q <= (remain != '0);
        head_q  <= (remain != '0) ? mem[rd_idx] : '0;
      end
    end

    assign s_axis_h2c_tready[c]                                 = ready_q;
    assign m_axis_c2h_tvalid[c]                                 = valid_q;
    assign m_axis_c2h_tlast[c]                                  = head_q[EW-1];
    assign m_axis_c2h_tkeep[c*BYTE_BIT_ENABLE +: BYTE_BIT_ENABLE] = head_q[DATA_WIDTH +: BYTE_BIT_ENABLE];
    assign m_axis_c2h_tdata[c*DATA_WIDTH +: DATA_WIDTH]         = head_q[DATA_WIDTH-1:0];

    assign pend_sat = (pend_q == {PEND_W{1'b1}});

    // IRQ next state; GAP goes straight back to REQ when work is pending
    always_comb begin
      state_n   = state_q;
      enter_req = 1'b0;
      case (state_q)
        IRQ_IDLE: begin
          if (pend_q != '0 || pkt_done) begin
            state_n   = IRQ_REQ;
            enter_req = 1'b1;
          end
        end
        IRQ_REQ: begin
          if (irq_ack[c]) state_n = IRQ_GAP;
        end
        IRQ_GAP: begin
          if (pend_q != '0) begin
            state_n   = IRQ_REQ;
            enter_req = 1'b1;
          end else begin
            state_n = IRQ_IDLE;
          end
        end
        default: state_n = IRQ_IDLE;
      endcase
    end

    always_ff @(posedge user_clk or negedge user_rst) begin
      if (!user_rst) begin
        state_q <= IRQ_IDLE;
        irq_q   <= 1'b0;
        pend_q  <= '0;
      end else begin
        state_q <= state_n;
        irq_q   <= (state_n == IRQ_REQ);
        if (pkt_done && !enter_req && !pend_sat) begin
          pend_q <= pend_q + PEND_W'(1);
        end else if (!pkt_done && enter_req) begin
          pend_q <= pend_q - PEND_W'(1);
        end
      end
    end

    assign irq_req[c] = irq_q;

`ifdef DMA_LB_STATS_EN
    logic [31:0]       pkt_cnt_q;
    logic [PEND_W-1:0] drop_q;
    logic              pend_drop;

    assign pend_drop = pkt_done & pend_sat & ~enter_req;

    always_ff @(posedge user_clk or negedge user_rst) begin
      if (!user_rst) begin
        pkt_cnt_q <= '0;
        drop_q    <= '0;
      end else begin
        pkt_cnt_q <= pkt_cnt_q + 32'(pkt_done);
        if (pend_drop && drop_q != {PEND_W{1'b1}}) drop_q <= drop_q + PEND_W'(1);
      end
    end

    assign pkt_cnt[c*32 +: 32]          = pkt_cnt_q;
    assign drop_cnt[c*PEND_W +: PEND_W] = drop_q;
`endif
  end

endmodule

// File: tb/tb_dma_lb_mc.sv
// Directed bench for dma_lb_mc: vector table for the basic packet path, hand sequences for corner cases.
module tb_dma_lb_mc;
  localparam int DW    = 128;
  localparam int KW    = DW / 8;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int NV    = 10;

  logic               user_clk = 1'b0;
  logic               user_rst;
  logic [NCH*DW-1:0]  h2c_tdata;
  logic [NCH*KW-1:0]  h2c_tkeep;
  logic [NCH-1:0]     h2c_tlast, h2c_tvalid, h2c_tready;
  logic [NCH*DW-1:0]  c2h_tdata;
  logic [NCH*KW-1:0]  c2h_tkeep;
  logic [NCH-1:0]     c2h_tlast, c2h_tvalid, c2h_tready;
  logic [NCH-1:0]     irq_req, irq_ack;
`ifdef DMA_LB_STATS_EN
  logic [NCH*32-1:0]  pkt_cnt;
  logic [NCH*PW-1:0]  drop_cnt;
`endif

  always #5 user_clk = ~user_clk;

  dma_lb_mc #(
    .TCQ(1), .DATA_WIDTH(DW), .BYTE_BIT_ENABLE(KW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .PEND_W(PW)
  ) dut (
    .user_clk(user_clk), .user_rst(user_rst),
    .s_axis_h2c_tdata(h2c_tdata), .s_axis_h2c_tkeep(h2c_tkeep), .s_axis_h2c_tlast(h2c_tlast),
    .s_axis_h2c_tvalid(h2c_tvalid), .s_axis_h2c_tready(h2c_tready),
    .m_axis_c2h_tdata(c2h_tdata), .m_axis_c2h_tkeep(c2h_tkeep), .m_axis_c2h_tlast(c2h_tlast),
    .m_axis_c2h_tvalid(c2h_tvalid), .m_axis_c2h_tready(c2h_tready),
`ifdef DMA_LB_STATS_EN
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
`endif
    .irq_req(irq_req), .irq_ack(irq_ack)
  );

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic [KW-1:0] keep;
    logic          last;
    logic          crdy;
    logic          ack;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    logic [KW-1:0] e_keep;
    logic          e_last;
    logic          e_irq;
  } vec_t;

  vec_t          tbl [NV];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] rxq [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic vld, input logic [DW-1:0] dat, input logic [KW-1:0] keep,
                               input logic last, input logic crdy, input logic ack,
                               input logic e_vld, input logic [DW-1:0] e_dat, input logic [KW-1:0] e_keep,
                               input logic e_last, input logic e_irq);
    vec_t v;
    v.vld = vld; v.dat = dat; v.keep = keep; v.last = last; v.crdy = crdy; v.ack = ack;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_keep = e_keep; v.e_last = e_last; v.e_irq = e_irq;
    return v;
  endfunction

  task automatic idle_inputs();
    h2c_tvalid = '0; h2c_tdata = '0; h2c_tkeep = '0; h2c_tlast = '0;
    c2h_tready = '1; irq_ack = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    user_rst = 1'b0;
    step();
    step();
    user_rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, first_low;
    logic hs_in, hs_out;

    // Basic 4-beat packet on ch0, one-cycle latency, irq raise/ack
    tbl[0] = mkv(1, 128'h1, 16'hFFFF, 0, 1, 0,  0, 128'h0, 16'h0000, 0, 0);
    tbl[1] = mkv(1, 128'h2, 16'hFFFF, 0, 1, 0,  1, 128'h1, 16'hFFFF, 0, 0);
    tbl[2] = mkv(1, 128'h3, 16'hFFFF, 0, 1, 0,  1, 128'h2, 16'hFFFF, 0, 0);
    tbl[3] = mkv(1, 128'h4, 16'h00FF, 1, 1, 0,  1, 128'h3, 16'hFFFF, 0, 0);
    tbl[4] = mkv(0, 128'h0, 16'h0000, 0, 1, 0,  1, 128'h4, 16'h00FF, 1, 0);
    tbl[5] = mkv(0, 128'h0, 16'h0000, 0, 1, 0,  0, 128'h0, 16'h0000, 0, 1);
    tbl[6] = mkv(0, 128'h0, 16'h0000, 0, 1, 0,  0, 128'h0, 16'h0000, 0, 1);
    tbl[7] = mkv(0, 128'h0, 16'h0000, 0, 1, 1,  0, 128'h0, 16'h0000, 0, 0);
    tbl[8] = mkv(0, 128'h0, 16'h0000, 0, 1, 0,  0, 128'h0, 16'h0000, 0, 0);
    tbl[9] = mkv(0, 128'h0, 16'h0000, 0, 1, 0,  0, 128'h0, 16'h0000, 0, 0);

    idle_inputs();
    user_rst = 1'b0;
    step();
    step();
    chk("rst.h2c_tready", h2c_tready, 0);
    chk("rst.c2h_tvalid", c2h_tvalid, 0);
    chk("rst.c2h_tlast",  c2h_tlast, 0);
    chk("rst.c2h_tdata0", c2h_tdata[DW-1:0], 0);
    chk("rst.c2h_tdata1", c2h_tdata[2*DW-1:DW], 0);
    chk("rst.c2h_tkeep",  c2h_tkeep, 0);
    chk("rst.irq_req",    irq_req, 0);
    user_rst = 1'b1;
    step();
    chk("rel.h2c_tready", h2c_tready, 2'b11);
    chk("rel.c2h_tvalid", c2h_tvalid, 0);

    for (int r = 0; r < NV; r++) begin
      h2c_tvalid[0]      = tbl[r].vld;
      h2c_tdata[DW-1:0]  = tbl[r].dat;
      h2c_tkeep[KW-1:0]  = tbl[r].keep;
      h2c_tlast[0]       = tbl[r].last;
      c2h_tready[0]      = tbl[r].crdy;
      irq_ack[0]         = tbl[r].ack;
      step();
      chk($sformatf("v%0d.c2h_tvalid", r), c2h_tvalid[0], tbl[r].e_vld);
      chk($sformatf("v%0d.c2h_tdata", r),  c2h_tdata[DW-1:0], tbl[r].e_dat);
      chk($sformatf("v%0d.c2h_tkeep", r),  c2h_tkeep[KW-1:0], tbl[r].e_keep);
      chk($sformatf("v%0d.c2h_tlast", r),  c2h_tlast[0], tbl[r].e_last);
      chk($sformatf("v%0d.irq_req0", r),   irq_req[0], tbl[r].e_irq);
      chk($sformatf("v%0d.h2c_tready0", r), h2c_tready[0], 1);
      chk($sformatf("v%0d.ch1_tvalid", r), c2h_tvalid[1], 0);
      chk($sformatf("v%0d.ch1_irq", r),    irq_req[1], 0);
    end
    idle_inputs();

    // 20 words against a stalled C2H: ready drops after the 16th accept, then all drain in order
    c2h_tready[0] = 1'b0;
    acc = 0;
    first_low = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      h2c_tvalid[0]     = 1'b1;
      h2c_tdata[DW-1:0] = DW'(32'hA00 + acc);
      h2c_tkeep[KW-1:0] = 16'hFFFF;
      hs_in = h2c_tready[0];
      if (!hs_in && first_low < 0) first_low = acc;
      step();
      if (hs_in) acc++;
    end
    chk("A.accepted_while_stalled", 128'(acc), 16);
    chk("A.tready_low_after", 128'(first_low), 16);
    chk("A.h2c_tready_full", h2c_tready[0], 0);
    c2h_tready[0] = 1'b1;
    got = 0;
    rxq.delete();
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      h2c_tvalid[0]     = (acc < 20);
      h2c_tdata[DW-1:0] = DW'(32'hA00 + acc);
      hs_in  = h2c_tvalid[0] & h2c_tready[0];
      hs_out = c2h_tvalid[0];
      if (hs_out) rxq.push_back(c2h_tdata[DW-1:0]);
      step();
      if (hs_in) acc++;
      if (hs_out) got++;
    end
    chk("A.words_out", 128'(got), 20);
    for (int i = 0; i < rxq.size(); i++) chk($sformatf("A.word%0d", i), rxq[i], DW'(32'hA00 + i));
    idle_inputs();
    step();

    // Fill to full, no push at full, then push+pop at count 15
    c2h_tready[0] = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < DEPTH; cyc++) begin
      h2c_tvalid[0]     = 1'b1;
      h2c_tdata[DW-1:0] = DW'(32'hB00 + acc);
      hs_in = h2c_tready[0];
      step();
      if (hs_in) acc++;
    end
    chk("B.filled", 128'(acc), DEPTH);
    h2c_tdata[DW-1:0] = DW'(32'hBFF);
    step();
    chk("B.full_ready0_a", h2c_tready[0], 0);
    step();
    chk("B.full_ready0_b", h2c_tready[0], 0);
    rxq.delete();
    h2c_tvalid[0] = 1'b0;
    c2h_tready[0] = 1'b1;
    chk("B.head_valid", c2h_tvalid[0], 1);
    rxq.push_back(c2h_tdata[DW-1:0]);
    step();
    chk("B.ready_at15", h2c_tready[0], 1);
    h2c_tvalid[0]     = 1'b1;
    h2c_tdata[DW-1:0] = DW'(32'hB10);
    chk("B.pp_valid", c2h_tvalid[0], 1);
    rxq.push_back(c2h_tdata[DW-1:0]);
    step();
    chk("B.ready_after_pp", h2c_tready[0], 1);
    h2c_tvalid[0] = 1'b0;
    c2h_tready[0] = 1'b0;
    step();
    chk("B.count_still15", h2c_tready[0], 1);
    h2c_tvalid[0]     = 1'b1;
    h2c_tdata[DW-1:0] = DW'(32'hB11);
    step();
    chk("B.full_again", h2c_tready[0], 0);
    h2c_tvalid[0] = 1'b0;
    c2h_tready[0] = 1'b1;
    for (int cyc = 0; cyc < 40 && rxq.size() < 18; cyc++) begin
      if (c2h_tvalid[0]) rxq.push_back(c2h_tdata[DW-1:0]);
      step();
    end
    chk("B.words_out", 128'(rxq.size()), 18);
    for (int i = 0; i < rxq.size(); i++) chk($sformatf("B.word%0d", i), rxq[i], DW'(32'hB00 + i));
    step();
    chk("B.empty", c2h_tvalid[0], 0);

    // Three packets complete while ack is withheld
    for (int i = 0; i < 3; i++) begin
      h2c_tvalid[0]     = 1'b1;
      h2c_tdata[DW-1:0] = DW'(32'hC00 + i);
      h2c_tkeep[KW-1:0] = 16'hFFFF;
      h2c_tlast[0]      = 1'b1;
      chk($sformatf("C.tready%0d", i), h2c_tready[0], 1);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("C.irq_held%0d", i), irq_req[0], 1);
    end
    for (int k = 0; k < 3; k++) begin
      irq_ack[0] = 1'b1;
      step();
      irq_ack[0] = 1'b0;
      chk($sformatf("C.gap%0d", k), irq_req[0], 0);
      step();
      chk($sformatf("C.after_gap%0d", k), irq_req[0], (k < 2) ? 1 : 0);
      if (k < 2) begin
        step();
        chk($sformatf("C.req_hold%0d", k), irq_req[0], 1);
      end
    end
    step();
    chk("C.idle", irq_req[0], 0);

    // 20 packets with no ack: pending saturates at 15
    do_reset();
    acc = 0;
    for (int cyc = 0; cyc < 60 && acc < 20; cyc++) begin
      h2c_tvalid[0]     = 1'b1;
      h2c_tdata[DW-1:0] = DW'(32'hD00 + acc);
      h2c_tkeep[KW-1:0] = 16'hFFFF;
      h2c_tlast[0]      = 1'b1;
      hs_in = h2c_tready[0];
      step();
      if (hs_in) acc++;
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    chk("D.pushed", 128'(acc), 20);
    chk("D.irq_up", irq_req[0], 1);
`ifdef DMA_LB_STATS_EN
    chk("D.pkt_cnt0", pkt_cnt[31:0], 20);
    chk("D.pkt_cnt1", pkt_cnt[63:32], 0);
    chk("D.drop_cnt0", drop_cnt[PW-1:0], 4);
`endif
    got = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (irq_req[0]) begin
        irq_ack[0] = 1'b1;
        step();
        irq_ack[0] = 1'b0;
        got++;
      end else begin
        step();
      end
    end
    chk("D.req_count", 128'(got), 16);
    chk("D.irq_final", irq_req[0], 0);

    // Reset mid-packet on both channels
    h2c_tkeep = '1;
    c2h_tready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      h2c_tvalid           = 2'b11;
      h2c_tdata[DW-1:0]    = DW'(32'hE00 + i);
      h2c_tdata[2*DW-1:DW] = DW'(32'hE10 + i);
      h2c_tlast            = {(i == 0), 1'b0};
      step();
    end
    h2c_tvalid = '0;
    h2c_tlast  = '0;
    for (int i = 0; i < 3; i++) step();
    chk("E.pre_irq1", irq_req[1], 1);
    chk("E.pre_valid0", c2h_tvalid[0], 1);
    #2;
    user_rst = 1'b0;
    #1;
    chk("E.rst_h2c_tready", h2c_tready, 0);
    chk("E.rst_c2h_tvalid", c2h_tvalid, 0);
    chk("E.rst_c2h_tlast",  c2h_tlast, 0);
    chk("E.rst_tdata0",     c2h_tdata[DW-1:0], 0);
    chk("E.rst_tdata1",     c2h_tdata[2*DW-1:DW], 0);
    chk("E.rst_tkeep",      c2h_tkeep, 0);
    chk("E.rst_irq",        irq_req, 0);
    step();
    step();
    user_rst = 1'b1;
    step();
    chk("E.rel_h2c_tready", h2c_tready, 2'b11);
    chk("E.rel_c2h_tvalid", c2h_tvalid, 0);
    c2h_tready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("E.no_stale%0d", i), c2h_tvalid, 0);
      chk($sformatf("E.no_irq%0d", i), irq_req, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
